// File: rtl/spi_cmd_framer.sv
// SPI mode-0 slave front end: oversamples SCK/MOSI/SSEL on clk, frames command and
// parameter bytes, and shifts the decoder's reply byte out on MISO.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_WAIT_IDLE | after reset; wait for SSEL high so a half-seen frame is ignored
// S_IDLE      | SSEL high; wait for SSEL falling edge to start a frame
// S_ACTIVE    | frame in progress; shift bits, strobe completed bytes
module spi_cmd_framer #(
    parameter int   SYNC_STAGES = 2,
    parameter logic MISO_IDLE   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SCK,
    input  logic        MOSI,
    input  logic        SSEL,
    output logic        MISO,
    input  logic [7:0]  tx_data,
    output logic        cmd_ready,
    output logic        param_ready,
    output logic [7:0]  cmd_data,
    output logic [7:0]  param_data,
    output logic [31:0] byte_cnt,
    output logic [2:0]  bit_cnt,
    output logic        frame_end
);

    localparam logic [1:0] S_WAIT_IDLE = 2'd0;
    localparam logic [1:0] S_IDLE      = 2'd1;
    localparam logic [1:0] S_ACTIVE    = 2'd2;

    logic [1:0]             state;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] ssel_sync;
    logic                   sck_prev;
    logic                   ssel_prev;
    logic                   sck_s;
    logic                   mosi_s;
    logic                   ssel_s;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   ssel_fall;
    logic                   byte_done;
    logic [7:0]             rx_sh;
    logic [7:0]             rx_next;
    logic [7:0]             tx_sh;
    logic [31:0]            cnt_next;
    logic                   load_pend;

    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign ssel_s    = ssel_sync[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_prev;
    assign sck_fall  = ~sck_s & sck_prev;
    assign ssel_fall = ~ssel_s & ssel_prev;
    assign byte_done = sck_rise && (bit_cnt == 3'd7);
    assign rx_next   = {rx_sh[6:0], mosi_s};
    assign cnt_next  = (byte_cnt == 32'hFFFF_FFFF) ? byte_cnt : byte_cnt + 32'd1;

    assign MISO = (state == S_ACTIVE) ? tx_sh[7] : MISO_IDLE;

    // SSEL chain resets low so WAIT_IDLE only leaves on a genuinely high SSEL.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            ssel_sync <= '0;
            sck_prev  <= 1'b0;
            ssel_prev <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], SSEL};
            sck_prev  <= sck_s;
            ssel_prev <= ssel_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_WAIT_IDLE;
            bit_cnt     <= 3'd0;
            byte_cnt    <= 32'd0;
            rx_sh       <= 8'h00;
            tx_sh       <= 8'h00;
            load_pend   <= 1'b0;
            cmd_data    <= 8'h00;
            param_data  <= 8'h00;
            cmd_ready   <= 1'b0;
            param_ready <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            cmd_ready   <= 1'b0;
            param_ready <= 1'b0;
            frame_end   <= 1'b0;
            case (state)
                S_WAIT_IDLE: begin
                    if (ssel_s)
                        state <= S_IDLE;
                end
                S_IDLE: begin
                    if (ssel_fall) begin
                        bit_cnt   <= 3'd0;
                        byte_cnt  <= 32'd0;
                        rx_sh     <= 8'h00;
                        tx_sh     <= 8'h00;
                        load_pend <= 1'b0;
                        state     <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    // A byte finishing with SSEL rising is strobed first; the
                    // still-high SSEL level ends the frame on the next clk.
                    if (ssel_s && !byte_done) begin
                        bit_cnt   <= 3'd0;
                        frame_end <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        if (sck_rise) begin
                            rx_sh   <= rx_next;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (byte_done) begin
                                byte_cnt  <= cnt_next;
                                load_pend <= 1'b1;
                                if (cnt_next == 32'd1) begin
                                    cmd_data  <= rx_next;
                                    cmd_ready <= 1'b1;
                                end else begin
                                    param_data  <= rx_next;
                                    param_ready <= 1'b1;
                                end
                            end
                        end
                        if (sck_fall) begin
                            if (load_pend) begin
                                tx_sh     <= tx_data;
                                load_pend <= 1'b0;
                            end else begin
                                tx_sh <= {tx_sh[6:0], 1'b0};
                            end
                        end
                    end
                end
                default: state <= S_WAIT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_framer.sv
// Directed bench for spi_cmd_framer: frames, MISO reply, aborts, reset mid-frame,
// SSEL/SCK coincidence and strobe latency for two synchroniser depths.
module tb_spi_cmd_framer;

    localparam int H = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        SCK = 1'b0;
    logic        MOSI = 1'b0;
    logic        SSEL = 1'b1;
    logic [7:0]  tx_data = 8'h00;

    logic        MISO, cmd_ready, param_ready, frame_end;
    logic [7:0]  cmd_data, param_data;
    logic [31:0] byte_cnt;
    logic [2:0]  bit_cnt;

    logic        miso3, cmd_ready3, param_ready3, frame_end3;
    logic [7:0]  cmd_data3, param_data3;
    logic [31:0] byte_cnt3;
    logic [2:0]  bit_cnt3;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_rise_cyc = 0;

    int n_cmd = 0, n_param = 0, n_fe = 0, both_hi = 0, n_cmd3 = 0;
    logic [7:0]  cmd_val = 8'h00, cmd3_val = 8'h00;
    logic [31:0] cmd_cntv = 32'd0;
    logic [7:0]  param_val [0:31];
    logic [31:0] param_cntv [0:31];
    int cmd_cyc = 0, param_cyc = 0, fe_cyc = 0, cmd3_cyc = 0;

    spi_cmd_framer #(.SYNC_STAGES(2), .MISO_IDLE(1'b1)) dut (
        .clk(clk), .rst(rst), .SCK(SCK), .MOSI(MOSI), .SSEL(SSEL), .MISO(MISO),
        .tx_data(tx_data), .cmd_ready(cmd_ready), .param_ready(param_ready),
        .cmd_data(cmd_data), .param_data(param_data), .byte_cnt(byte_cnt),
        .bit_cnt(bit_cnt), .frame_end(frame_end)
    );

    spi_cmd_framer #(.SYNC_STAGES(3), .MISO_IDLE(1'b1)) dut3 (
        .clk(clk), .rst(rst), .SCK(SCK), .MOSI(MOSI), .SSEL(SSEL), .MISO(miso3),
        .tx_data(tx_data), .cmd_ready(cmd_ready3), .param_ready(param_ready3),
        .cmd_data(cmd_data3), .param_data(param_data3), .byte_cnt(byte_cnt3),
        .bit_cnt(bit_cnt3), .frame_end(frame_end3)
    );

    always #5 clk = ~clk;

    // Event log of strobes, sampled 1 time unit after the active edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (cmd_ready && param_ready) both_hi = both_hi + 1;
        if (cmd_ready) begin
            n_cmd = n_cmd + 1; cmd_val = cmd_data; cmd_cntv = byte_cnt; cmd_cyc = cyc;
        end
        if (param_ready) begin
            param_val[n_param % 32] = param_data;
            param_cntv[n_param % 32] = byte_cnt;
            n_param = n_param + 1; param_cyc = cyc;
        end
        if (frame_end) begin
            n_fe = n_fe + 1; fe_cyc = cyc;
        end
        if (cmd_ready3) begin
            n_cmd3 = n_cmd3 + 1; cmd3_val = cmd_data3; cmd3_cyc = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            MOSI = b[i];
            tick(H);
            r[i] = MISO;
            SCK = 1'b1;
            last_rise_cyc = cyc;
            tick(H);
            SCK = 1'b0;
        end
    endtask

    task automatic frame_start();
        SSEL = 1'b0;
        tick(H);
    endtask

    task automatic frame_stop();
        tick(H);
        SSEL = 1'b1;
        tick(2 * H);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(6);
        checks++; if (MISO !== 1'b1) begin errors++; $display("FAIL reset_miso: got %b expected 1", MISO); end
        checks++; if (byte_cnt !== 32'd0) begin errors++; $display("FAIL reset_byte_cnt: got %0d expected 0", byte_cnt); end
        checks++; if (bit_cnt !== 3'd0) begin errors++; $display("FAIL reset_bit_cnt: got %0d expected 0", bit_cnt); end
        checks++; if ({cmd_data, param_data} !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", {cmd_data, param_data}); end
        checks++; if ({cmd_ready, param_ready, frame_end} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b expected 000", {cmd_ready, param_ready, frame_end}); end
        rst = 1'b0;
        tick(8);
    endtask

    task automatic test_frame();
        logic [7:0] r;
        int c0, p0, f0;
        c0 = n_cmd; p0 = n_param; f0 = n_fe;
        frame_start();
        spi_bits(8'h12, 8, r);
        spi_bits(8'hAB, 8, r);
        spi_bits(8'hCD, 8, r);
        frame_stop();
        checks++; if (n_cmd - c0 !== 1) begin errors++; $display("FAIL frame_cmd_count: got %0d expected 1", n_cmd - c0); end
        checks++; if (cmd_val !== 8'h12 || cmd_cntv !== 32'd1) begin errors++; $display("FAIL frame_cmd: got %h/%0d expected 12/1", cmd_val, cmd_cntv); end
        checks++; if (n_param - p0 !== 2) begin errors++; $display("FAIL frame_param_count: got %0d expected 2", n_param - p0); end
        checks++; if (param_val[p0 % 32] !== 8'hAB || param_cntv[p0 % 32] !== 32'd2) begin errors++; $display("FAIL frame_param1: got %h/%0d expected AB/2", param_val[p0 % 32], param_cntv[p0 % 32]); end
        checks++; if (param_val[(p0 + 1) % 32] !== 8'hCD || param_cntv[(p0 + 1) % 32] !== 32'd3) begin errors++; $display("FAIL frame_param2: got %h/%0d expected CD/3", param_val[(p0 + 1) % 32], param_cntv[(p0 + 1) % 32]); end
        checks++; if (n_fe - f0 !== 1) begin errors++; $display("FAIL frame_end_count: got %0d expected 1", n_fe - f0); end
        checks++; if (MISO !== 1'b1) begin errors++; $display("FAIL frame_idle_miso: got %b expected 1", MISO); end
    endtask

    task automatic test_miso();
        logic [7:0] r1, r2;
        bit seen;
        tx_data = 8'h00;
        seen = 1'b0;
        frame_start();
        fork
            begin
                spi_bits(8'hF0, 8, r1);
                spi_bits(8'h00, 8, r2);
            end
            begin
                for (int k = 0; k < 400 && !seen; k++) begin
                    @(negedge clk);
                    if (cmd_ready) seen = 1'b1;
                end
                tick(2);
                tx_data = 8'hA5;
            end
        join
        frame_stop();
        checks++; if (!seen) begin errors++; $display("FAIL miso_cmd_wait: got no cmd_ready expected one within 400 clk"); end
        checks++; if (r1 !== 8'h00) begin errors++; $display("FAIL miso_byte1: got %h expected 00", r1); end
        checks++; if (r2 !== 8'hA5) begin errors++; $display("FAIL miso_byte2: got %h expected A5", r2); end
        tx_data = 8'h00;
    endtask

    task automatic test_abort();
        logic [7:0] r;
        int p0, f0;
        frame_start();
        spi_bits(8'h5A, 8, r);
        p0 = n_param; f0 = n_fe;
        spi_bits(8'hFF, 5, r);
        checks++; if (bit_cnt !== 3'd5) begin errors++; $display("FAIL abort_bit_cnt_mid: got %0d expected 5", bit_cnt); end
        SSEL = 1'b1;
        tick(2 * H);
        checks++; if (n_param - p0 !== 0) begin errors++; $display("FAIL abort_no_param: got %0d expected 0", n_param - p0); end
        checks++; if (n_fe - f0 !== 1) begin errors++; $display("FAIL abort_frame_end: got %0d expected 1", n_fe - f0); end
        checks++; if (bit_cnt !== 3'd0) begin errors++; $display("FAIL abort_bit_cnt: got %0d expected 0", bit_cnt); end
        checks++; if (byte_cnt !== 32'd1) begin errors++; $display("FAIL abort_byte_cnt: got %0d expected 1", byte_cnt); end
        checks++; if (cmd_data !== 8'h5A) begin errors++; $display("FAIL abort_cmd_kept: got %h expected 5A", cmd_data); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] r;
        int c0, p0, f0;
        frame_start();
        spi_bits(8'h33, 8, r);
        spi_bits(8'h44, 3, r);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++; if ({byte_cnt, bit_cnt, cmd_data} !== 43'd0) begin errors++; $display("FAIL rstmid_outputs: got %0d/%0d/%h expected 0/0/00", byte_cnt, bit_cnt, cmd_data); end
        checks++; if (MISO !== 1'b1) begin errors++; $display("FAIL rstmid_miso: got %b expected 1", MISO); end
        c0 = n_cmd; p0 = n_param; f0 = n_fe;
        spi_bits(8'h00, 8, r);
        checks++; if (r !== 8'hFF) begin errors++; $display("FAIL rstmid_miso_idle: got %h expected FF", r); end
        SSEL = 1'b1;
        tick(2 * H);
        checks++; if (n_cmd - c0 + n_param - p0 + n_fe - f0 !== 0) begin errors++; $display("FAIL rstmid_no_strobes: got %0d expected 0", n_cmd - c0 + n_param - p0 + n_fe - f0); end
        c0 = n_cmd; p0 = n_param;
        frame_start();
        spi_bits(8'h77, 8, r);
        spi_bits(8'h88, 8, r);
        frame_stop();
        checks++; if (n_cmd - c0 !== 1 || cmd_val !== 8'h77) begin errors++; $display("FAIL rstmid_next_cmd: got %0d/%h expected 1/77", n_cmd - c0, cmd_val); end
        checks++; if (n_param - p0 !== 1 || param_val[p0 % 32] !== 8'h88 || param_cntv[p0 % 32] !== 32'd2) begin errors++; $display("FAIL rstmid_next_param: got %0d/%h/%0d expected 1/88/2", n_param - p0, param_val[p0 % 32], param_cntv[p0 % 32]); end
    endtask

    task automatic test_ssel_with_last_bit();
        logic [7:0] r;
        logic [7:0] b;
        int p0, f0;
        b = 8'h3C;
        frame_start();
        spi_bits(8'h01, 8, r);
        p0 = n_param; f0 = n_fe;
        spi_bits(b, 7, r);
        MOSI = b[0];
        tick(H);
        SCK = 1'b1;
        SSEL = 1'b1;
        tick(H);
        SCK = 1'b0;
        tick(2 * H);
        checks++; if (n_param - p0 !== 1 || param_val[p0 % 32] !== 8'h3C || param_cntv[p0 % 32] !== 32'd2) begin errors++; $display("FAIL coinc_param: got %0d/%h/%0d expected 1/3C/2", n_param - p0, param_val[p0 % 32], param_cntv[p0 % 32]); end
        checks++; if (n_fe - f0 !== 1) begin errors++; $display("FAIL coinc_fe_count: got %0d expected 1", n_fe - f0); end
        checks++; if (fe_cyc - param_cyc !== 1) begin errors++; $display("FAIL coinc_fe_delay: got %0d expected 1", fe_cyc - param_cyc); end
    endtask

    task automatic test_latency();
        logic [7:0] r;
        int c0, c3;
        c0 = n_cmd; c3 = n_cmd3;
        frame_start();
        spi_bits(8'h9E, 8, r);
        frame_stop();
        checks++; if (n_cmd3 - c3 !== 1 || cmd3_val !== 8'h9E) begin errors++; $display("FAIL lat3_cmd: got %0d/%h expected 1/9E", n_cmd3 - c3, cmd3_val); end
        checks++; if (cmd3_cyc - last_rise_cyc !== 4) begin errors++; $display("FAIL lat3_cycles: got %0d expected 4", cmd3_cyc - last_rise_cyc); end
        checks++; if (n_cmd - c0 !== 1 || cmd_cyc - last_rise_cyc !== 3) begin errors++; $display("FAIL lat2_cycles: got %0d/%0d expected 1/3", n_cmd - c0, cmd_cyc - last_rise_cyc); end
        checks++; if (both_hi !== 0) begin errors++; $display("FAIL exclusive_strobes: got %0d expected 0", both_hi); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_miso();
        test_abort();
        test_reset_mid_frame();
        test_ssel_with_last_bit();
        test_latency();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
